inst_fetch_queue: RTL

Instruction fetch queue between the fetch stage (PC register + instruction ROM) and the decode (ID) stage, replacing the plain IF/ID pipeline register. It captures each fetched {pc, inst} pair into a small FIFO and presents the head to ID through a registered output. This decouples fetch from decode stalls; fetch is throttled only when the queue is full. Stall semantics follow the pipeline's 6-bit `stall` vector from the control unit: bit 0 is PC, bit 1 is IF, bit 2 is ID; 1 means stop.

---
 rtl/inst_fetch_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between IF and ID: buffers fetched {pc, inst} pairs in a small FIFO
// and presents the head to decode through a registered output, with bypass when empty.
module inst_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    stall,
    input  logic          flush,
    input  logic          if_ce,
    input  logic [AW-1:0] if_pc,
    input  logic [DW-1:0] if_inst,
    output logic [AW-1:0] id_pc,
    output logic [DW-1:0] id_inst,
    output logic          id_valid,
    output logic          stallreq_if,
    output logic          ovf_err
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] Full = (PW + 1)'(DEPTH);

    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [DW-1:0]    inst_q, inst_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             enq, pop, push, bypass, full;

    // The PC only advances when stall[0] is low, so only then is the current fetch consumed.
    assign enq  = if_ce & ~stall[0];
    assign full = (cnt_q == Full);

    always_comb begin
        pc_d     = pc_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        push     = 1'b0;
        bypass   = 1'b0;
        if (flush) begin
            pc_d     = '0;
            inst_d   = '0;
            valid_d  = 1'b0;
            ovf_d    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // stall[2] holds the output register untouched.
            if (!stall[2]) begin
                if (stall[1]) begin
                    pc_d    = '0;
                    inst_d  = '0;
                    valid_d = 1'b0;
                end else if (cnt_q != '0) begin
                    {pc_d, inst_d} = mem_q[rd_ptr_q];
                    valid_d        = 1'b1;
                    pop            = 1'b1;
                end else if (enq) begin
                    pc_d    = if_pc;
                    inst_d  = if_inst;
                    valid_d = 1'b1;
                    bypass  = 1'b1;
                end else begin
                    pc_d    = '0;
                    inst_d  = '0;
                    valid_d = 1'b0;
                end
            end
            if (enq && !bypass) begin
                if (!full || pop) begin
                    push = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + (PW + 1)'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - (PW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= '0;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {if_pc, if_inst};
        end
    end

    assign id_pc       = pc_q;
    assign id_inst     = inst_q;
    assign id_valid    = valid_q;
    assign stallreq_if = full;
    assign ovf_err     = ovf_q;

endmodule
